// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the CPU datapath (slave).
// The datapath supplies the opcode, ALU flags and memory ready; the sequencer returns per-cycle controls.
interface multicycle_ctrl_fsm_if;
    logic [3:0] opcode;
    logic       zero;
    logic       lt;
    logic       gt;
    logic       mem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       fault;

    modport master (
        input  opcode, zero, lt, gt, mem_ready,
        output pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               instr_done, illegal_op, fault
    );

    modport slave (
        output opcode, zero, lt, gt, mem_ready,
        input  pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               instr_done, illegal_op, fault
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls; MULTICYCLE_PERF_EN adds perf counters.
// Latency: Moore controls valid in the cycle of each state; 3-5 cycles per instruction plus memory wait cycles.
// Backpressure: memory states hold on mem_ready=0; more than MEM_WAIT_MAX wait cycles locks into FAULT until reset.
module multicycle_ctrl_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [15:0]           perf_instr,
    output logic [15:0]           perf_cycles
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_R,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       fault;
    } ctrl_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_t            ctrl, ctrl_out;
    logic             in_mem;
    logic             mem_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A ready arriving in the limit cycle still completes the access.
    always_comb begin
        in_mem      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        mem_timeout = in_mem && !bus.mem_ready && (MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_LIMIT);
        wait_cnt_d  = '0;
        if (in_mem && !bus.mem_ready && !mem_timeout) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end else if (mem_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                case (bus.opcode)
                    4'b0000:                            state_d = S_EXEC_R;
                    4'b0001, 4'b0010, 4'b0011, 4'b0100: state_d = S_EXEC_I;
                    4'b0111, 4'b1000:                   state_d = S_MEM_ADDR;
                    4'b1001, 4'b1010, 4'b1011, 4'b1100: state_d = S_BRANCH;
                    4'b1111:                            state_d = S_JUMP;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        ctrl.instr_done = 1'b1;
                        state_d         = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 3'b100;
                state_d        = S_WB_R;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                case (bus.opcode)
                    4'b0010: ctrl.alu_op = 3'b010;
                    4'b0011: ctrl.alu_op = 3'b011;
                    4'b0100: ctrl.alu_op = 3'b001;
                    default: ctrl.alu_op = 3'b000;
                endcase
                state_d = S_WB_I;
            end
            S_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = (bus.opcode == 4'b0111) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (mem_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end else if (mem_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = 3'b001;
                ctrl.pc_src     = 2'b01;
                ctrl.instr_done = 1'b1;
                ctrl.pc_write   = ((bus.opcode == 4'b1001) &&  bus.zero) ||
                                  ((bus.opcode == 4'b1010) && !bus.zero) ||
                                  ((bus.opcode == 4'b1011) &&  bus.lt)   ||
                                  ((bus.opcode == 4'b1100) &&  bus.gt);
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = 2'b10;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Forcing controls low during reset guarantees no partial write lands after an abandoned instruction.
    always_comb begin
        ctrl_out = reset ? '0 : ctrl;
    end

    assign bus.pc_write   = ctrl_out.pc_write;
    assign bus.pc_src     = ctrl_out.pc_src;
    assign bus.iord       = ctrl_out.iord;
    assign bus.mem_read   = ctrl_out.mem_read;
    assign bus.mem_write  = ctrl_out.mem_write;
    assign bus.ir_write   = ctrl_out.ir_write;
    assign bus.reg_write  = ctrl_out.reg_write;
    assign bus.reg_dst    = ctrl_out.reg_dst;
    assign bus.mem_to_reg = ctrl_out.mem_to_reg;
    assign bus.alu_src_a  = ctrl_out.alu_src_a;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.instr_done = ctrl_out.instr_done;
    assign bus.illegal_op = ctrl_out.illegal_op;
    assign bus.fault      = ctrl_out.fault;

`ifdef MULTICYCLE_PERF_EN
    logic [15:0] perf_instr_q, perf_instr_d;
    logic [15:0] perf_cycles_q, perf_cycles_d;

    always_comb begin
        perf_instr_d  = perf_instr_q + {15'd0, ctrl.instr_done};
        perf_cycles_d = (state_q != S_FAULT) ? perf_cycles_q + 16'd1 : perf_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_q  <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_instr_q  <= perf_instr_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_instr  = reset ? 16'd0 : perf_instr_q;
    assign perf_cycles = reset ? 16'd0 : perf_cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: each instruction is expanded into its expected per-cycle control words.
// Directed cases cover wait-limit edges, timeout fault, illegal opcodes and reset inside a store.
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus ();

`ifdef MULTICYCLE_PERF_EN
    logic [15:0] perf_instr, perf_cycles;
`endif

    multicycle_ctrl_fsm #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MULTICYCLE_PERF_EN
        ,
        .perf_instr  (perf_instr),
        .perf_cycles (perf_cycles)
`endif
    );

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       fault;
    } cw_t;

    cw_t   exp_q[$];
    bit    rdy_q[$];
    string tag_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_instr  = 16'd0;
    logic [15:0] m_cycles = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cw_t observed();
        cw_t o;
        o.pc_write   = bus.pc_write;
        o.pc_src     = bus.pc_src;
        o.iord       = bus.iord;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.reg_write  = bus.reg_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.instr_done = bus.instr_done;
        o.illegal_op = bus.illegal_op;
        o.fault      = bus.fault;
        return o;
    endfunction

    task automatic push(input cw_t w, input bit rdy, input string tag);
        exp_q.push_back(w);
        rdy_q.push_back(rdy);
        tag_q.push_back(tag);
    endtask

    // Expected cycle sequence of one instruction; wf/wd are the mem_ready-low cycles before fetch/data completes.
    task automatic build_instr(input logic [3:0] op, input bit z, input bit l, input bit g,
                               input int wf, input int wd);
        cw_t w;
        for (int i = 0; i < wf; i++) begin
            w = '0; w.mem_read = 1'b1; w.alu_src_b = 2'b01;
            push(w, 1'b0, "fetch_wait");
        end
        w = '0; w.mem_read = 1'b1; w.alu_src_b = 2'b01; w.ir_write = 1'b1; w.pc_write = 1'b1;
        push(w, 1'b1, "fetch");
        w = '0; w.alu_src_b = 2'b11;
        case (op)
            4'd0: begin
                push(w, 1'($urandom), "decode");
                w = '0; w.alu_src_a = 1'b1; w.alu_op = 3'b100;
                push(w, 1'($urandom), "exec_r");
                w = '0; w.reg_write = 1'b1; w.reg_dst = 1'b1; w.instr_done = 1'b1;
                push(w, 1'($urandom), "wb_r");
            end
            4'd1, 4'd2, 4'd3, 4'd4: begin
                push(w, 1'($urandom), "decode");
                w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
                w.alu_op = (op == 4'd1) ? 3'b000 : (op == 4'd2) ? 3'b010 : (op == 4'd3) ? 3'b011 : 3'b001;
                push(w, 1'($urandom), "exec_i");
                w = '0; w.reg_write = 1'b1; w.instr_done = 1'b1;
                push(w, 1'($urandom), "wb_i");
            end
            4'd7, 4'd8: begin
                push(w, 1'($urandom), "decode");
                w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
                push(w, 1'($urandom), "mem_addr");
                w = '0; w.iord = 1'b1;
                if (op == 4'd7) w.mem_read = 1'b1; else w.mem_write = 1'b1;
                for (int i = 0; i < wd; i++) push(w, 1'b0, "mem_wait");
                if (op == 4'd7) begin
                    push(w, 1'b1, "mem_rd");
                    w = '0; w.reg_write = 1'b1; w.mem_to_reg = 1'b1; w.instr_done = 1'b1;
                    push(w, 1'($urandom), "wb_mem");
                end else begin
                    w.instr_done = 1'b1;
                    push(w, 1'b1, "mem_wr");
                end
            end
            4'd9, 4'd10, 4'd11, 4'd12: begin
                push(w, 1'($urandom), "decode");
                w = '0; w.alu_src_a = 1'b1; w.alu_op = 3'b001; w.pc_src = 2'b01; w.instr_done = 1'b1;
                w.pc_write = (op == 4'd9 && z) || (op == 4'd10 && !z) || (op == 4'd11 && l) || (op == 4'd12 && g);
                push(w, 1'($urandom), "branch");
            end
            4'd15: begin
                push(w, 1'($urandom), "decode");
                w = '0; w.pc_write = 1'b1; w.pc_src = 2'b10; w.instr_done = 1'b1;
                push(w, 1'($urandom), "jump");
            end
            default: begin
                w.illegal_op = 1'b1; w.instr_done = 1'b1;
                push(w, 1'($urandom), "illegal");
            end
        endcase
    endtask

    task automatic run_queue();
        cw_t   e;
        string tag;
        while (exp_q.size() > 0) begin
            e             = exp_q.pop_front();
            bus.mem_ready = rdy_q.pop_front();
            tag           = tag_q.pop_front();
            @(negedge clk);
            chk(tag, {13'd0, observed()}, {13'd0, e});
`ifdef MULTICYCLE_PERF_EN
            chk("perf_instr", {16'd0, perf_instr}, {16'd0, m_instr});
            chk("perf_cycles", {16'd0, perf_cycles}, {16'd0, m_cycles});
`endif
            if (!e.fault) m_cycles = m_cycles + 16'd1;
            if (e.instr_done) m_instr = m_instr + 16'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_out", {13'd0, observed()}, 32'd0);
`ifdef MULTICYCLE_PERF_EN
            chk("rst_perf", {perf_instr, perf_cycles}, 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        m_instr  = 16'd0;
        m_cycles = 16'd0;
    endtask

    task automatic run_instr(input logic [3:0] op, input bit z, input bit l, input bit g,
                             input int wf, input int wd);
        bus.opcode = op; bus.zero = z; bus.lt = l; bus.gt = g;
        build_instr(op, z, l, g, wf, wd);
        run_queue();
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return 0;
        if (r == 1) return 15;
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        cw_t w;
        reset = 1'b1;
        bus.opcode = 4'd0; bus.zero = 1'b0; bus.lt = 1'b0; bus.gt = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(4'd1, 1'b0, 1'b0, 1'b0, 0, 0);   // addi
        run_instr(4'd7, 1'b0, 1'b0, 1'b0, 0, 3);   // lhw with 3 wait cycles
        run_instr(4'd9, 1'b1, 1'b0, 1'b0, 0, 0);   // beq taken
        run_instr(4'd10, 1'b1, 1'b0, 1'b0, 0, 0);  // bne not taken
        run_instr(4'd5, 1'b0, 1'b0, 1'b0, 0, 0);   // illegal
        run_instr(4'd8, 1'b0, 1'b0, 1'b0, 15, 15); // both waits at the limit
        run_instr(4'd0, 1'b0, 1'b0, 1'b0, 2, 0);
        run_instr(4'd15, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), pick_wait(), pick_wait());
        end

        // Timeout: 15 tolerated low cycles plus the limit cycle, then FAULT ignores mem_ready.
        bus.opcode = 4'd1;
        for (int i = 0; i < 16; i++) begin
            w = '0; w.mem_read = 1'b1; w.alu_src_b = 2'b01;
            push(w, 1'b0, "fetch_to");
        end
        for (int i = 0; i < 4; i++) begin
            w = '0; w.fault = 1'b1;
            push(w, 1'b1, "fault");
        end
        run_queue();
        do_reset();
        run_instr(4'd1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Reset while a store is waiting in its write state.
        bus.opcode = 4'd8;
        build_instr(4'd8, 1'b0, 1'b0, 1'b0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            void'(exp_q.pop_back());
            void'(rdy_q.pop_back());
            void'(tag_q.pop_back());
        end
        run_queue();
        do_reset();
        run_instr(4'd3, 1'b0, 1'b0, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
